// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - button synchroniser, debouncer and frame-aligned auto-repeat
// Three identical channels {down, right, left} feed one frame-registered output stage.
module key_conditioner #(
  parameter int DB_BITS   = 16,
  parameter int DB_COUNT  = 50000,
  parameter int RPT_DELAY = 12,
  parameter int RPT_RATE  = 4,
  parameter int DOWN_RATE = 2
) (
  input  logic       vclk,
  input  logic       rst,
  input  logic       frame,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  output logic       LEFT,
  output logic       RIGHT,
  output logic       DOWN,
  output logic [2:0] held
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_COUNT - 1);
  localparam logic [7:0]         DELAY_L = 8'(RPT_DELAY);

  logic [2:0] btn_raw;
  logic [2:0] lvl_w;
  logic [2:0] pend_w;
  logic [1:0] prime_q;

  assign btn_raw = {btn_down, btn_right, btn_left};
  assign held    = lvl_w;

  // Marks when the synchronisers hold real samples, so a held button is not mistaken for a release.
  always_ff @(posedge vclk) begin
    if (!rst) prime_q <= 2'b00;
    else      prime_q <= {prime_q[0], 1'b1};
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam logic [7:0] RATE = 8'((c == 2) ? DOWN_RATE : RPT_RATE);

    logic               s1_q, s2_q, lvl_q, arm_q, pend_q;
    logic [DB_BITS-1:0] dbc_q;
    logic [7:0]         fcnt_q;
    state_e             st_q;
    logic               flip, rise, fall, set_p;
    logic [7:0]         fcnt_inc;

    assign lvl_w[c]  = lvl_q;
    assign pend_w[c] = pend_q;

    always_comb begin
      flip     = (s2_q != lvl_q) && (dbc_q == DB_LAST);
      rise     = flip & ~lvl_q;
      fall     = flip & lvl_q;
      fcnt_inc = fcnt_q + 8'd1;
      set_p    = 1'b0;
      if (!fall) begin
        case (st_q)
          IDLE:    set_p = rise & arm_q;
          HOLD:    set_p = frame && (fcnt_inc == DELAY_L);
          REPEAT:  set_p = frame && (fcnt_inc == RATE);
          default: set_p = 1'b0;
        endcase
      end
    end

    always_ff @(posedge vclk) begin
      if (!rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        dbc_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        s1_q <= btn_raw[c];
        s2_q <= s1_q;
        if (s2_q == lvl_q) begin
          dbc_q <= '0;
        end else if (flip) begin
          dbc_q <= '0;
          lvl_q <= ~lvl_q;
        end else begin
          dbc_q <= dbc_q + 1'b1;
        end
      end
    end

    always_ff @(posedge vclk) begin
      if (!rst) begin
        st_q   <= IDLE;
        fcnt_q <= 8'd0;
        arm_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        if (prime_q[1] && !s2_q && !lvl_q) arm_q <= 1'b1;
        if (fall) begin
          st_q   <= IDLE;
          fcnt_q <= 8'd0;
        end else begin
          case (st_q)
            IDLE: if (rise && arm_q) begin
              st_q   <= HOLD;
              fcnt_q <= 8'd0;
            end
            HOLD: if (frame) begin
              if (fcnt_inc == DELAY_L) begin
                st_q   <= REPEAT;
                fcnt_q <= 8'd0;
              end else begin
                fcnt_q <= fcnt_inc;
              end
            end
            REPEAT: if (frame) fcnt_q <= (fcnt_inc == RATE) ? 8'd0 : fcnt_inc;
            default: st_q <= IDLE;
          endcase
        end
        // A request raised in the frame-pulse cycle survives the clear and goes out next frame.
        pend_q <= set_p | (pend_q & ~frame);
      end
    end
  end

  always_ff @(posedge vclk) begin
    if (!rst) begin
      LEFT  <= 1'b0;
      RIGHT <= 1'b0;
      DOWN  <= 1'b0;
    end else if (frame) begin
      LEFT  <= pend_w[0] & ~pend_w[1];
      RIGHT <= pend_w[1] & ~pend_w[0];
      DOWN  <= pend_w[2];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;
  logic       vclk = 1'b0;
  logic       rst = 1'b0;
  logic       frame = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_down = 1'b0;
  logic       LEFT, RIGHT, DOWN;
  logic [2:0] held;

  int n_cmp = 0;
  int n_err = 0;
  int fc = 0;
  bit fr_seen = 1'b0;

  key_conditioner #(
    .DB_BITS(16), .DB_COUNT(4), .RPT_DELAY(3), .RPT_RATE(2), .DOWN_RATE(1)
  ) dut (
    .vclk(vclk), .rst(rst), .frame(frame),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .LEFT(LEFT), .RIGHT(RIGHT), .DOWN(DOWN), .held(held)
  );

  always #5 vclk = ~vclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame pulse on every 20th cycle; outputs sampled 1 time unit after each edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      frame = (fc == 0);
      @(posedge vclk);
      #1;
      fr_seen = frame;
      fc = (fc + 1) % 20;
    end
  endtask

  task automatic to_frame();
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!fr_seen && guard < 25);
    if (!fr_seen) check("frame_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    int cnt;
    logic exp_b;

    // Reset with left already held
    btn_left = 1'b1;
    tick(3);
    check("rst_left", {7'd0, LEFT}, 8'd0);
    check("rst_right", {7'd0, RIGHT}, 8'd0);
    check("rst_down", {7'd0, DOWN}, 8'd0);
    check("rst_held", {5'd0, held}, 8'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      to_frame();
      check($sformatf("blocked_left_f%0d", k), {7'd0, LEFT}, 8'd0);
    end
    check("blocked_held", {5'd0, held}, 8'd1);
    btn_left = 1'b0;
    tick(30);
    check("released_held", {5'd0, held}, 8'd0);
    to_frame();
    btn_left = 1'b1;
    to_frame();
    check("repress_left", {7'd0, LEFT}, 8'd1);
    btn_left = 1'b0;
    to_frame();
    check("repress_left_end", {7'd0, LEFT}, 8'd0);
    to_frame();

    // Debounce: 3-cycle glitch rejected, long press toggles after 2+4 cycles
    btn_right = 1'b1;
    tick(3);
    btn_right = 1'b0;
    tick(10);
    check("glitch_held", {5'd0, held}, 8'd0);
    to_frame();
    check("glitch_right_a", {7'd0, RIGHT}, 8'd0);
    to_frame();
    check("glitch_right_b", {7'd0, RIGHT}, 8'd0);
    btn_right = 1'b1;
    tick(5);
    check("db_held_early", {5'd0, held}, 8'd0);
    tick(1);
    check("db_held_on", {5'd0, held}, 8'd2);
    tick(4);
    btn_right = 1'b0;
    to_frame();
    check("db_right_req", {7'd0, RIGHT}, 8'd1);
    to_frame();
    check("db_right_end", {7'd0, RIGHT}, 8'd0);
    to_frame();

    // Single tap: exactly one frame of LEFT
    btn_left = 1'b1;
    to_frame();
    btn_left = 1'b0;
    cnt = (LEFT === 1'b1) ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (LEFT === 1'b1) cnt++;
    end
    check("tap_cycles", 8'(cnt), 8'd20);
    tick();
    check("tap_end", {7'd0, LEFT}, 8'd0);
    to_frame();
    to_frame();

    // Auto-repeat left: frames 1,4,6,8,10,12 after press
    btn_left = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      to_frame();
      if (k == 12) btn_left = 1'b0;
      exp_b = (k == 1) || (k >= 4 && k <= 12 && (k % 2) == 0);
      check($sformatf("rep_left_k%0d", k), {7'd0, LEFT}, {7'd0, exp_b});
    end
    to_frame();

    // Auto-repeat down at rate 1: frames 1,4,5,6
    btn_down = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      to_frame();
      if (k == 5) btn_down = 1'b0;
      exp_b = (k == 1) || (k >= 4 && k <= 6);
      check($sformatf("rep_down_k%0d", k), {7'd0, DOWN}, {7'd0, exp_b});
    end
    to_frame();

    // Conflict: left+right cancel, down unaffected
    btn_left = 1'b1;
    btn_right = 1'b1;
    btn_down = 1'b1;
    to_frame();
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_down = 1'b0;
    check("conf_left", {7'd0, LEFT}, 8'd0);
    check("conf_right", {7'd0, RIGHT}, 8'd0);
    check("conf_down", {7'd0, DOWN}, 8'd1);
    to_frame();
    check("conf_down_end", {7'd0, DOWN}, 8'd0);
    to_frame();
    to_frame();

    // Race: debounced rise lands on the frame-pulse cycle
    tick(14);
    btn_left = 1'b1;
    to_frame();
    check("race_left_k1", {7'd0, LEFT}, 8'd0);
    btn_left = 1'b0;
    to_frame();
    check("race_left_k2", {7'd0, LEFT}, 8'd1);
    to_frame();
    check("race_left_k3", {7'd0, LEFT}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
